// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states,
// instruction classes and the control-field values driven to the datapath.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_LUI, CLS_NONE
    } instr_class_t;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_PASS   = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/op_decoder.sv
// Purely combinational opcode classifier: legality, instruction class,
// immediate format and ALU operation, zero-extended to the configured widths.
module op_decoder
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W  = 2,
    parameter int IMM_SRC_W = 3
) (
    input  logic [6:0]           opcode,
    output logic                 legal,
    output logic [2:0]           cls,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [IMM_SRC_W-1:0] imm_src
);

    instr_class_t cls_e;
    logic [1:0]   alu_base;
    logic [2:0]   imm_base;

    // NOTE: every output of this block is given a default before the case,
    // so no opcode leaves a value unassigned and no latch is inferred.
    always_comb begin
        legal    = 1'b1;
        cls_e    = CLS_NONE;
        alu_base = ALU_ADD;
        imm_base = IMM_I;
        case (opcode)
            OP_R:      begin cls_e = CLS_R;      alu_base = ALU_FUNCT;  end
            OP_I:      begin cls_e = CLS_I;      alu_base = ALU_FUNCT;  end
            OP_LOAD:   begin cls_e = CLS_LOAD;                         end
            OP_STORE:  begin cls_e = CLS_STORE;  imm_base = IMM_S;     end
            OP_BRANCH: begin cls_e = CLS_BRANCH; alu_base = ALU_BRANCH; imm_base = IMM_B; end
            OP_JAL:    begin cls_e = CLS_JAL;    imm_base = IMM_J;     end
            OP_LUI:    begin cls_e = CLS_LUI;    alu_base = ALU_PASS;   imm_base = IMM_U; end
            default:   legal = 1'b0;
        endcase
    end

    assign cls     = cls_e;
    assign alu_op  = ALU_OP_W'(alu_base);
    assign imm_src = IMM_SRC_W'(imm_base);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction controller FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define ILLEGAL_TRAP_EN to make illegal opcodes lock into TRAP until reset.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W  = 2,
    parameter int IMM_SRC_W = 3,
    parameter int PC_SRC_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 retire,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [IMM_SRC_W-1:0] imm_src,
    output logic [PC_SRC_W-1:0]  pc_src,
    output logic [1:0]           result_src,
    output logic                 illegal
);

    state_t                state, state_nxt;
    logic [6:0]            op_q;
    logic [6:0]            dec_opcode;
    logic                  dec_legal;
    logic [2:0]            dec_cls;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic [IMM_SRC_W-1:0]  dec_imm_src;
    instr_class_t          cls;

    // The live opcode is only meaningful in DECODE; later states use the latched copy.
    assign dec_opcode = (state == DECODE) ? opcode : op_q;

    op_decoder #(
        .ALU_OP_W  (ALU_OP_W),
        .IMM_SRC_W (IMM_SRC_W)
    ) u_op_decoder (
        .opcode  (dec_opcode),
        .legal   (dec_legal),
        .cls     (dec_cls),
        .alu_op  (dec_alu_op),
        .imm_src (dec_imm_src)
    );

    assign cls = instr_class_t'(dec_cls);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE) op_q <= opcode;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        alu_op     = '0;
        imm_src    = '0;
        pc_src     = '0;
        result_src = RES_ALU;
        illegal    = 1'b0;

        // Reset forces every output low in the same cycle, aborting any access.
        if (rst) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_W'(PC_PLUS4);
                        state_nxt = DECODE;
                    end
                end
                DECODE: begin
                    imm_src = dec_imm_src;
                    if (dec_legal) begin
                        state_nxt = EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_nxt = TRAP;
`else
                        state_nxt = FETCH;
`endif
                    end
                end
                EXEC: begin
                    alu_op  = dec_alu_op;
                    imm_src = dec_imm_src;
                    case (cls)
                        CLS_R, CLS_I, CLS_LUI: state_nxt = WB;
                        CLS_LOAD, CLS_STORE:   state_nxt = MEM;
                        CLS_JAL: begin
                            reg_write  = 1'b1;
                            result_src = RES_PC4;
                            pc_src     = PC_SRC_W'(PC_JUMP);
                            pc_write   = 1'b1;
                            retire     = 1'b1;
                            state_nxt  = FETCH;
                        end
                        CLS_BRANCH: begin
                            pc_src    = PC_SRC_W'(PC_BRANCH);
                            pc_write  = zero;
                            retire    = 1'b1;
                            state_nxt = FETCH;
                        end
                        default: state_nxt = FETCH;
                    endcase
                end
                MEM: begin
                    imm_src   = dec_imm_src;
                    mem_req   = 1'b1;
                    mem_write = (cls == CLS_STORE);
                    if (mem_ready) begin
                        if (cls == CLS_STORE) begin
                            retire    = 1'b1;
                            state_nxt = FETCH;
                        end else begin
                            state_nxt = WB;
                        end
                    end
                end
                WB: begin
                    reg_write  = 1'b1;
                    result_src = (cls == CLS_LOAD) ? RES_MEM : RES_ALU;
                    retire     = 1'b1;
                    state_nxt  = FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                TRAP: begin
                    illegal = 1'b1;
                end
`endif
                default: state_nxt = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: a per-instruction
// cycle model built from the latency and strobe rules is replayed against the DUT.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, ir_write, pc_write, reg_write, retire, illegal;
    logic [1:0] alu_op, pc_src, result_src;
    logic [2:0] imm_src;

    always #5 clk = ~clk;

    multicycle_control #(
        .ALU_OP_W  (2),
        .IMM_SRC_W (3),
        .PC_SRC_W  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .retire     (retire),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .pc_src     (pc_src),
        .result_src (result_src),
        .illegal    (illegal)
    );

    // Observed vector: {mem_req,mem_write,ir_write,pc_write,reg_write,retire,illegal,alu_op,imm_src,pc_src,result_src}
    localparam logic [15:0] M_STR = 16'hFE00;
    localparam logic [15:0] M_ALU = 16'h0180;
    localparam logic [15:0] M_IMM = 16'h0070;
    localparam logic [15:0] M_PCS = 16'h000C;
    localparam logic [15:0] M_RS  = 16'h0003;
    localparam logic [15:0] M_ALL = 16'hFFFF;

    typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_LUI, K_ILL} kind_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        zero;
        logic [6:0]  opc;
        logic [15:0] exp;
        logic [15:0] mask;
        string       tag;
    } cyc_t;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic kind_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b0110111: return K_LUI;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [1:0] alu_for(input kind_t k);
        case (k)
            K_R, K_I: return 2'b10;
            K_BR:     return 2'b01;
            K_LUI:    return 2'b11;
            default:  return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] imm_for(input kind_t k);
        case (k)
            K_ST:    return 3'b001;
            K_BR:    return 3'b010;
            K_JAL:   return 3'b011;
            K_LUI:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic push(input string tag, input logic r, input logic rdy, input logic z,
                        input logic [6:0] opc, input logic [15:0] exp, input logic [15:0] mask);
        cyc_t e;
        e.rst = r; e.rdy = rdy; e.zero = z; e.opc = opc;
        e.exp = exp; e.mask = mask; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic push_rnd(input string tag, input logic rdy, input logic [15:0] exp,
                            input logic [15:0] mask);
        push(tag, 1'b0, rdy, 1'($urandom), 7'($urandom), exp, mask);
    endtask

    task automatic add_idle();
        push_rnd("fetch_hold", 1'b0, {7'b1000000, 9'd0}, M_STR);
    endtask

    // One instruction's expected cycle sequence, from the per-class rules.
    task automatic add_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
        kind_t      k;
        logic [1:0] a;
        logic [2:0] im;
        logic       st;
        k  = classify(op);
        a  = alu_for(k);
        im = imm_for(k);
        st = (k == K_ST);
        for (int i = 0; i < fw; i++)
            push_rnd("fetch_wait", 1'b0, {7'b1000000, 9'd0}, M_STR);
        push_rnd("fetch_ready", 1'b1, {7'b1011000, 2'b00, 3'b000, 2'b00, 2'b00}, M_STR | M_PCS);
        push("decode", 1'b0, 1'($urandom), 1'($urandom), op, 16'd0, M_STR);
        if (k == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
            for (int i = 0; i < 4; i++)
                push_rnd("trap", 1'($urandom), {7'b0000001, 9'd0}, M_STR);
`endif
            return;
        end
        case (k)
            K_JAL:   push_rnd("exec_jal", 1'($urandom), {7'b0001110, a, im, 2'b10, 2'b10},
                              M_STR | M_IMM | M_PCS | M_RS);
            K_BR:    push("exec_branch", 1'b0, 1'($urandom), z, 7'($urandom),
                          {3'b000, z, 3'b010, a, im, 2'b01, 2'b00}, M_STR | M_ALU | M_IMM | M_PCS);
            default: push_rnd("exec", 1'($urandom), {7'b0000000, a, im, 4'b0000}, M_STR | M_ALU | M_IMM);
        endcase
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < mw; i++)
                push_rnd("mem_wait", 1'b0, {1'b1, st, 5'b00000, 9'd0}, M_STR);
            push_rnd("mem_ready", 1'b1, {1'b1, st, 3'b000, st, 1'b0, 9'd0}, M_STR);
        end
        if (k == K_R || k == K_I || k == K_LUI || k == K_LD)
            push_rnd("wb", 1'($urandom), {7'b0000110, 7'd0, (k == K_LD) ? 2'b01 : 2'b00}, M_STR | M_RS);
    endtask

    task automatic step(input cyc_t e, output logic [15:0] obs);
        @(negedge clk);
        rst       = e.rst;
        mem_ready = e.rdy;
        zero      = e.zero;
        opcode    = e.opc;
        #1;
        obs = {mem_req, mem_write, ir_write, pc_write, reg_write, retire, illegal,
               alu_op, imm_src, pc_src, result_src};
    endtask

    task automatic test_reset();
        cyc_t e;
        logic [15:0] obs;
        q.delete();
        for (int i = 0; i < 3; i++)
            push("in_reset", 1'b1, 1'b1, 1'($urandom), 7'($urandom), 16'd0, M_ALL);
        add_idle();
        while (q.size() != 0) begin
            e = q.pop_front();
            step(e, obs);
            n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL reset/%s: got %h required %h (mask %h)", e.tag, obs, e.exp, e.mask);
            end
        end
    endtask

    task automatic test_rtype();
        cyc_t e;
        logic [15:0] obs;
        q.delete();
        add_instr(7'b0110011, 0, 0, 1'b0);
        add_idle();
        while (q.size() != 0) begin
            e = q.pop_front();
            step(e, obs);
            n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL rtype/%s: got %h required %h (mask %h)", e.tag, obs, e.exp, e.mask);
            end
        end
    endtask

    task automatic test_load_store();
        cyc_t e;
        logic [15:0] obs;
        q.delete();
        add_instr(7'b0000011, 0, 3, 1'b0);
        add_instr(7'b0100011, 1, 1, 1'b0);
        add_instr(7'b0100011, 0, 0, 1'b1);
        add_idle();
        while (q.size() != 0) begin
            e = q.pop_front();
            step(e, obs);
            n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL load_store/%s: got %h required %h (mask %h)", e.tag, obs, e.exp, e.mask);
            end
        end
    endtask

    task automatic test_branch_jump();
        cyc_t e;
        logic [15:0] obs;
        q.delete();
        add_instr(7'b1100011, 0, 0, 1'b1);
        add_instr(7'b1100011, 0, 0, 1'b0);
        add_instr(7'b1101111, 2, 0, 1'b0);
        add_instr(7'b0110111, 0, 0, 1'b0);
        add_instr(7'b0010011, 0, 0, 1'b1);
        add_idle();
        while (q.size() != 0) begin
            e = q.pop_front();
            step(e, obs);
            n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL branch_jump/%s: got %h required %h (mask %h)", e.tag, obs, e.exp, e.mask);
            end
        end
    endtask

    task automatic test_illegal();
        cyc_t e;
        logic [15:0] obs;
        q.delete();
        add_instr(7'b1111111, 0, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 2; i++)
            push("trap_reset", 1'b1, 1'($urandom), 1'($urandom), 7'($urandom), 16'd0, M_ALL);
`endif
        add_idle();
        add_instr(7'b0110011, 0, 0, 1'b0);
        add_idle();
        while (q.size() != 0) begin
            e = q.pop_front();
            step(e, obs);
            n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL illegal/%s: got %h required %h (mask %h)", e.tag, obs, e.exp, e.mask);
            end
        end
    endtask

    task automatic test_reset_in_mem();
        cyc_t e;
        logic [15:0] obs;
        q.delete();
        add_instr(7'b0100011, 0, 1, 1'b0);
        void'(q.pop_back());
        push("rst_in_mem", 1'b1, 1'b0, 1'($urandom), 7'($urandom), 16'd0, M_ALL);
        add_idle();
        add_instr(7'b0000011, 0, 0, 1'b0);
        add_idle();
        while (q.size() != 0) begin
            e = q.pop_front();
            step(e, obs);
            n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL reset_in_mem/%s: got %h required %h (mask %h)", e.tag, obs, e.exp, e.mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t e;
        logic [15:0] obs;
        logic [6:0]  ops [7];
        logic [6:0]  op;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b0110111};
        q.delete();
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 6)];
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                op = 7'($urandom);
                if (classify(op) != K_ILL) op = 7'b1111111;
            end
`endif
            add_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end
        add_idle();
        while (q.size() != 0) begin
            e = q.pop_front();
            step(e, obs);
            n_checks++;
            if ((obs & e.mask) !== (e.exp & e.mask)) begin
                n_fail++;
                $display("FAIL back_to_back/%s: got %h required %h (mask %h)", e.tag, obs, e.exp, e.mask);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_store();
        test_branch_jump();
        test_reset_in_mem();
        test_illegal();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 2: alu_op width; legal values 2 or more.
REQ-002 SHALL have parameter IMM_SRC_W, default 3: imm_src width; legal values 3 or more.
REQ-003 SHALL have parameter PC_SRC_W, default 2: pc_src width; legal values 2 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port opcode, input, 7 bits: instruction opcode field; sampled only in DECODE.
REQ-007 SHALL have port zero, input, 1 bit: ALU zero flag; used only in EXEC for branches.
REQ-008 SHALL have port mem_ready, input, 1 bit: memory accepts the current request.
REQ-009 SHALL have outputs mem_req, mem_write, ir_write, pc_write, reg_write and retire, each 1 bit.
REQ-010 SHALL have outputs alu_op (ALU_OP_W), imm_src (IMM_SRC_W), pc_src (PC_SRC_W) and result_src (2 bits: 00 ALU, 01 memory, 10 PC+4).
REQ-011 SHALL have output illegal, 1 bit: sticky illegal-opcode flag.

Function
REQ-012 SHALL implement states FETCH, DECODE, EXEC, MEM, WB and TRAP. Outputs are combinational from state, op_q, zero and mem_ready.
REQ-013 FETCH: mem_req=1 and hold until mem_ready=1. On the ready cycle: ir_write=1, pc_write=1, pc_src=00, then go to DECODE. A zero-wait ready, on the first FETCH cycle, SHALL be accepted.
REQ-014 DECODE: latch opcode into op_q. A legal opcode goes to EXEC. An illegal opcode goes to FETCH, or to TRAP when the REQ-025 macro is defined. No write strobes in DECODE.
REQ-015 The legal opcode set is: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, JAL 1101111, LUI 0110111.
REQ-016 imm_src by type: I/load 000, store 001, branch 010, JAL 011, LUI 100, R don't-care 000. Upper bits are zero-extended.
REQ-017 alu_op in EXEC by type: R/I-ALU 10, load/store 00, branch 01, LUI 11 (pass immediate). Upper bits are zero.
REQ-018 EXEC transitions:
- R, I-ALU, LUI go to WB.
- Load and store go to MEM.
- JAL: reg_write=1, result_src=10, pc_src=10, pc_write=1, retire=1, then FETCH.
- Branch: pc_src=01, pc_write=zero, retire=1, then FETCH.
REQ-019 MEM: mem_req=1, with mem_write=1 for store, held until mem_ready. On the ready cycle a store asserts retire and goes to FETCH; a load goes to WB.
REQ-020 WB: reg_write=1 for exactly one cycle, result_src=01 for load and 00 otherwise, retire=1, then FETCH.
REQ-021 retire SHALL pulse exactly once per completed legal instruction.
REQ-022 mem_ready SHALL be ignored in DECODE, EXEC and WB.
REQ-023 Latency in cycles, with zero-wait memory: R/I/LUI 4, load 5, store 4, branch/JAL 3.
REQ-024 In TRAP, illegal=1 and every other output is 0. TRAP is left only by rst.

Configuration
REQ-025 Macro ILLEGAL_TRAP_EN:
- Defined: illegal opcodes enter TRAP per REQ-024.
- Undefined: an illegal opcode returns to FETCH with no strobes and no retire, TRAP is not built, and illegal is tied to 0.
- The port list is identical either way.

Reset
REQ-026 While rst=1, every output SHALL be 0, including mem_req and mem_write, in the same cycle rst is asserted.
REQ-027 On the edge after rst is sampled 1, the state SHALL be FETCH and op_q SHALL be 0.
REQ-028 Reset during MEM SHALL abandon the access with no write strobe; the first cycle after rst deasserts SHALL be FETCH with mem_req=1.

Structure
REQ-029 Package ctrl_pkg SHALL hold:
- the opcode localparams;
- the state enum;
- the alu_op, imm_src and result_src encodings as localparams.
REQ-030 Combinational sub-module op_decoder SHALL map opcode to legal, imm_src, alu_op and instruction class. The FSM SHALL live in multicycle_control.

Verification
REQ-031 Reset, then R-type 0110011 with mem_ready=1 throughout -> ir_write at cycle 0, reg_write at cycle 3 with result_src=00, retire at cycle 3, mem_req again at cycle 4.
REQ-032 Load 0000011, with mem_ready low for 3 MEM cycles -> mem_req held 4 MEM cycles with mem_write=0, then WB with result_src=01 and reg_write for 1 cycle.
REQ-033 Store 0100011 -> mem_write=1 only in MEM, reg_write never set, retire on the MEM ready cycle.
REQ-034 Branch with zero=1, then with zero=0 -> pc_write=1 and pc_src=01 in EXEC, then pc_write=0 in EXEC; both retire.
REQ-035 Opcode 1111111 -> with ILLEGAL_TRAP_EN, illegal=1 and sticky with all strobes 0 until rst; without it, returns to FETCH, retire=0 and illegal=0.
REQ-036 rst asserted during MEM of a store with mem_ready=0 -> mem_write=0 in that cycle, and FETCH with mem_req=1 after release.
